// File: rtl/instruction_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_sequencer_pkg: shared widths, depth default, sequencer states. Rev 1.0
// ----------------------------------------------------------------------------
package instruction_sequencer_pkg;

  localparam int INSTR_W       = 12;
  localparam int DEPTH_DEFAULT = 16;
  localparam int COUNT_W       = 5;
  localparam int GAP_W         = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_sequencer_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_buffer: DEPTH x INSTR_W program store, sync write, async read. Rev 1.0
// ----------------------------------------------------------------------------
module instr_buffer
  import instruction_sequencer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  // Contents are deliberately not reset; count alone defines what is valid.
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_sequencer: loads a short program and replays it as paced execute strobes. Rev 1.0
// ----------------------------------------------------------------------------
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               abort,
  input  logic               clear,
  output logic [INSTR_W-1:0] instruction,
  output logic               exec_strobe,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  localparam int                 IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  seq_state_t         state, state_next;
  logic [IDX_W-1:0]   rd_idx, rd_idx_next;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
  logic [COUNT_W-1:0] count_next;
  logic               overflow_next;
  logic               capture;
  logic               wr_en;
  logic               is_last;
  logic [INSTR_W-1:0] rd_data;
  logic [INSTR_W-1:0] issue_word;

  assign wr_en   = (state == IDLE) && load_en && !clear && (count != DEPTH_C);
  assign is_last = (COUNT_W'(rd_idx) == (count - COUNT_W'(1)));

  instr_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[IDX_W-1:0]),
    .wr_data (load_data),
    .rd_addr (rd_idx_next),
    .rd_data (rd_data)
  );

  // A word written in the same cycle as start lands in slot 0 only when the
  // buffer was empty; forward it since the array still holds the old value.
  assign issue_word = (wr_en && (count[IDX_W-1:0] == rd_idx_next)) ? load_data : rd_data;

  always_comb begin
    state_next    = state;
    rd_idx_next   = rd_idx;
    gap_cnt_next  = gap_cnt;
    count_next    = count;
    overflow_next = overflow;
    capture       = 1'b0;

    case (state)
      IDLE: begin
        if (clear) begin
          count_next    = '0;
          overflow_next = 1'b0;
        end else if (load_en) begin
          if (count != DEPTH_C) begin
            count_next = count + COUNT_W'(1);
          end else begin
            overflow_next = 1'b1;
          end
        end
        if (start) begin
          if (count_next != '0) begin
            rd_idx_next = '0;
            capture     = 1'b1;
            state_next  = ISSUE;
          end else begin
            state_next  = FINISH;
          end
        end
      end

      ISSUE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = GAP_LOAD;
          state_next   = GAP;
        end
      end

      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (gap_cnt == '0) begin
          if (is_last) begin
            state_next = FINISH;
          end else begin
            rd_idx_next = rd_idx + IDX_W'(1);
            capture     = 1'b1;
            state_next  = ISSUE;
          end
        end else begin
          gap_cnt_next = gap_cnt - GAP_W'(1);
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_idx      <= '0;
      gap_cnt     <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      instruction <= '0;
    end else begin
      state    <= state_next;
      rd_idx   <= rd_idx_next;
      gap_cnt  <= gap_cnt_next;
      count    <= count_next;
      overflow <= overflow_next;
      if (capture) begin
        instruction <= issue_word;
      end
    end
  end

  assign exec_strobe = (state == ISSUE);
  assign busy        = (state == ISSUE) || (state == GAP);
  assign done        = (state == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instruction_sequencer: randomized playback checked against a schedule model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_instruction_sequencer;

  localparam int G0 = 4;
  localparam int G1 = 1;

  logic        clk = 1'b0;
  logic        reset, load_en, start, abort, clear;
  logic [11:0] load_data;
  logic [11:0] instruction, instruction1;
  logic        exec_strobe, busy, done, overflow;
  logic        exec_strobe1, busy1, done1, overflow1;
  logic [4:0]  count, count1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: the program is just the ordered list of accepted words.
  logic [11:0] prog[$];
  bit          model_ovf;

  int          s_cyc[$];
  logic [11:0] s_word[$];
  int          d_cyc[$];
  int          g_cyc[$];
  logic [11:0] g_word[$];
  int          g_done[$];
  bit          busy_seen;
  int          chg_bad = 0;
  logic [11:0] instr_prev;

  instruction_sequencer #(.DEPTH(16), .GAP_CYCLES(G0)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .start(start), .abort(abort), .clear(clear), .instruction(instruction),
    .exec_strobe(exec_strobe), .busy(busy), .done(done), .count(count),
    .overflow(overflow));

  instruction_sequencer #(.DEPTH(16), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .start(start), .abort(abort), .clear(clear), .instruction(instruction1),
    .exec_strobe(exec_strobe1), .busy(busy1), .done(done1), .count(count1),
    .overflow(overflow1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exec_strobe) begin
      s_cyc.push_back(cyc);
      s_word.push_back(instruction);
    end
    if (done) d_cyc.push_back(cyc);
    if (busy) busy_seen = 1'b1;
    if (instruction !== instr_prev && !exec_strobe && !reset) chg_bad++;
    instr_prev = instruction;
    if (exec_strobe1) begin
      g_cyc.push_back(cyc);
      g_word.push_back(instruction1);
    end
    if (done1) g_done.push_back(cyc);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    s_cyc.delete(); s_word.delete(); d_cyc.delete();
    g_cyc.delete(); g_word.delete(); g_done.delete();
    busy_seen = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_en = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0; load_data = '0;
    step(); step();
    reset = 1'b0;
    prog.delete();
    model_ovf = 1'b0;
  endtask

  task automatic load_word(input logic [11:0] w);
    load_en = 1'b1; load_data = w;
    step();
    load_en = 1'b0;
    if (prog.size() < 16) prog.push_back(w); else model_ovf = 1'b1;
  endtask

  // Pulses start (plus any load the caller already set up) and waits for done.
  task automatic play(input bit fast, input int budget, output int s);
    clear_logs();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0; load_en = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((fast ? g_done.size() : d_cyc.size()) != 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (instruction !== 12'h000) begin miscompares++; $display("FAIL reset_instruction: got %h expected 000", instruction); end
    vectors++; if (exec_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %b expected 0", exec_strobe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic test_basic_playback();
    int s;
    do_reset();
    load_word(12'hA01); load_word(12'h542); load_word(12'hC13);
    play(1'b0, 100, s);
    vectors++;
    if (s_cyc.size() != 3) begin miscompares++; $display("FAIL basic_strobes: got %0d expected 3", s_cyc.size()); end
    for (int i = 0; i < 3 && i < s_cyc.size(); i++) begin
      vectors++;
      if (s_cyc[i] != s + 1 + i * (G0 + 1) || s_word[i] !== prog[i]) begin
        miscompares++;
        $display("FAIL basic_strobe%0d: got cyc %0d word %h expected cyc %0d word %h",
                 i, s_cyc[i] - s, s_word[i], 1 + i * (G0 + 1), prog[i]);
      end
    end
    vectors++;
    if (d_cyc.size() != 1 || d_cyc[0] != s + 1 + 3 * (G0 + 1)) begin
      miscompares++;
      $display("FAIL basic_done: got %0d pulses first at %0d expected one at %0d",
               d_cyc.size(), d_cyc.size() ? d_cyc[0] - s : -1, 1 + 3 * (G0 + 1));
    end
    step();
    vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL basic_count: got %0d expected 3", count); end
  endtask

  task automatic test_overflow();
    int s;
    logic [11:0] w;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = 12'($urandom);
      if (w == 12'hFFF) w = 12'h000;
      load_word(w);
    end
    load_word(12'hFFF);
    vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL ovf_count: got %0d expected 16", count); end
    vectors++; if (overflow !== model_ovf) begin miscompares++; $display("FAIL ovf_flag: got %b expected %b", overflow, model_ovf); end
    play(1'b0, 200, s);
    vectors++;
    if (s_cyc.size() != 16) begin miscompares++; $display("FAIL ovf_strobes: got %0d expected 16", s_cyc.size()); end
    for (int i = 0; i < 16 && i < s_word.size(); i++) begin
      vectors++;
      if (s_word[i] !== prog[i]) begin miscompares++; $display("FAIL ovf_slot%0d: got %h expected %h", i, s_word[i], prog[i]); end
    end
    step();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clear = 1'b1; step(); clear = 1'b0;
    prog.delete(); model_ovf = 1'b0;
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL clr_count: got %0d expected 0", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_empty_start();
    int s;
    do_reset();
    clear = 1'b1; load_en = 1'b1; load_data = 12'h123;
    step();
    clear = 1'b0; load_en = 1'b0;
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL clear_priority: got %0d expected 0", count); end
    play(1'b0, 20, s);
    vectors++; if (s_cyc.size() != 0) begin miscompares++; $display("FAIL empty_strobes: got %0d expected 0", s_cyc.size()); end
    vectors++;
    if (d_cyc.size() != 1 || d_cyc[0] != s + 1) begin
      miscompares++;
      $display("FAIL empty_done: got %0d pulses first at %0d expected one at 1", d_cyc.size(), d_cyc.size() ? d_cyc[0] - s : -1);
    end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL empty_busy: got %b expected 0", busy_seen); end
    step();
  endtask

  task automatic test_abort();
    int s;
    do_reset();
    for (int i = 0; i < 4; i++) load_word(12'($urandom));
    clear_logs();
    s = cyc; start = 1'b1; step(); start = 1'b0;
    while (cyc < s + 8) step();
    abort = 1'b1; step(); abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy %b expected 0", busy); end
    for (int i = 0; i < 20; i++) step();
    vectors++; if (s_cyc.size() != 2) begin miscompares++; $display("FAIL abort_strobes: got %0d expected 2", s_cyc.size()); end
    vectors++; if (d_cyc.size() != 0) begin miscompares++; $display("FAIL abort_done: got %0d expected 0", d_cyc.size()); end
    vectors++; if (count !== 5'd4) begin miscompares++; $display("FAIL abort_count: got %0d expected 4", count); end
    play(1'b0, 100, s);
    vectors++;
    if (s_cyc.size() != 4 || s_word[0] !== prog[0] || s_word[3] !== prog[3]) begin
      miscompares++;
      $display("FAIL abort_replay: got %0d strobes first %h expected 4 first %h", s_cyc.size(), s_word.size() ? s_word[0] : 12'h0, prog[0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int s;
    do_reset();
    for (int i = 0; i < 3; i++) load_word(12'($urandom));
    clear_logs();
    s = cyc; start = 1'b1; step(); start = 1'b0;
    while (cyc < s + 1 + (G0 + 1)) step();
    vectors++; if (exec_strobe !== 1'b1) begin miscompares++; $display("FAIL mid_issue: got %b expected 1", exec_strobe); end
    reset = 1'b1; step();
    vectors++;
    if (count !== 5'd0 || instruction !== 12'h000 || exec_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got cnt %0d ins %h stb %b busy %b done %b ovf %b expected all zero",
               count, instruction, exec_strobe, busy, done, overflow);
    end
    reset = 1'b0; prog.delete(); model_ovf = 1'b0;
    for (int i = 0; i < 20; i++) step();
    vectors++; if (s_cyc.size() != 2) begin miscompares++; $display("FAIL mid_strobes: got %0d expected 2", s_cyc.size()); end
    vectors++; if (d_cyc.size() != 0) begin miscompares++; $display("FAIL mid_done: got %0d expected 0", d_cyc.size()); end
  endtask

  task automatic test_random();
    int s, n;
    logic [11:0] w;
    for (int it = 0; it < 8; it++) begin
      clear = 1'b1; step(); clear = 1'b0;
      prog.delete(); model_ovf = 1'b0;
      n = $urandom_range(16, 1);
      for (int i = 0; i < n - 1; i++) load_word(12'($urandom));
      w = 12'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        load_en = 1'b1; load_data = w; prog.push_back(w);
      end else begin
        load_word(w);
      end
      play(1'b0, 200, s);
      vectors++;
      if (s_cyc.size() != n) begin miscompares++; $display("FAIL rnd%0d_strobes: got %0d expected %0d", it, s_cyc.size(), n); end
      for (int i = 0; i < n && i < s_cyc.size(); i++) begin
        vectors++;
        if (s_cyc[i] != s + 1 + i * (G0 + 1) || s_word[i] !== prog[i]) begin
          miscompares++;
          $display("FAIL rnd%0d_strobe%0d: got cyc %0d word %h expected cyc %0d word %h",
                   it, i, s_cyc[i] - s, s_word[i], 1 + i * (G0 + 1), prog[i]);
        end
      end
      vectors++;
      if (d_cyc.size() != 1 || d_cyc[0] != s + 1 + n * (G0 + 1)) begin
        miscompares++;
        $display("FAIL rnd%0d_done: got %0d pulses expected one at %0d", it, d_cyc.size(), 1 + n * (G0 + 1));
      end
      step();
      vectors++; if (count !== 5'(n)) begin miscompares++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, count, n); end
    end
    vectors++; if (chg_bad != 0) begin miscompares++; $display("FAIL instr_stable: got %0d changes outside issue expected 0", chg_bad); end
  endtask

  task automatic test_gap1_same_cycle();
    int s;
    do_reset();
    load_word(12'h111); load_word(12'h222);
    load_en = 1'b1; load_data = 12'h333; prog.push_back(12'h333);
    play(1'b1, 50, s);
    vectors++;
    if (g_cyc.size() != 3) begin miscompares++; $display("FAIL g1_strobes: got %0d expected 3", g_cyc.size()); end
    for (int i = 0; i < 3 && i < g_cyc.size(); i++) begin
      vectors++;
      if (g_cyc[i] != s + 1 + i * (G1 + 1) || g_word[i] !== prog[i]) begin
        miscompares++;
        $display("FAIL g1_strobe%0d: got cyc %0d word %h expected cyc %0d word %h",
                 i, g_cyc[i] - s, g_word[i], 1 + i * (G1 + 1), prog[i]);
      end
    end
    vectors++;
    if (g_done.size() != 1 || g_done[0] != s + 1 + 3 * (G1 + 1)) begin
      miscompares++;
      $display("FAIL g1_done: got %0d pulses expected one at %0d", g_done.size(), 1 + 3 * (G1 + 1));
    end
    do_reset();
    load_en = 1'b1; load_data = 12'h5A5; prog.push_back(12'h5A5);
    play(1'b1, 50, s);
    vectors++;
    if (g_cyc.size() != 1 || g_word[0] !== 12'h5A5 || g_cyc[0] != s + 1) begin
      miscompares++;
      $display("FAIL g1_empty_load_start: got %0d strobes first %h expected 1 strobe 5a5", g_cyc.size(), g_word.size() ? g_word[0] : 12'h0);
    end
    vectors++;
    if (g_done.size() != 1 || g_done[0] != s + 1 + (G1 + 1)) begin
      miscompares++;
      $display("FAIL g1_single_done: got %0d pulses expected one at %0d", g_done.size(), 1 + (G1 + 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic_playback();
    test_overflow();
    test_empty_start();
    test_abort();
    test_reset_mid();
    test_random();
    test_gap1_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
